// File: rtl/df_demux_pkg.sv
// rtl/df_demux_pkg.sv - shared widths, constants and state encoding for the write-back distributor
package df_demux_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int SEL_WIDTH  = 3;
    localparam int NUM_SLOTS  = 7;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [SEL_WIDTH-1:0]  sel_t;

    // Q3.12 value of 1.0 served by the operand selector's slot 7
    localparam word_t CONST_ONE = 16'h1000;
    localparam sel_t  SEL_CONST = 3'h7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/df_demux_if.sv
// rtl/df_demux_if.sv - result-word stream with slot addressing into the distributor
interface df_demux_if;
    import df_demux_pkg::*;

    word_t in_data;
    logic  in_valid;
    logic  in_ready;
    logic  wr_sel_en;
    sel_t  wr_sel;

    modport master (output in_data, output in_valid, output wr_sel_en, output wr_sel, input in_ready);
    modport slave  (input in_data, input in_valid, input wr_sel_en, input wr_sel, output in_ready);

endinterface

// File: rtl/df_demux.sv
// rtl/df_demux.sv - scatters a result stream into seven holding slots and frames them for downstream
module df_demux
    import df_demux_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    df_demux_if.slave            wr,
    output word_t                data_out_0,
    output word_t                data_out_1,
    output word_t                data_out_2,
    output word_t                data_out_3,
    output word_t                data_out_4,
    output word_t                data_out_5,
    output word_t                data_out_6,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic                 frame_done,
    input  logic                 frame_ack,
    output logic                 err_const
);

    state_t                state_q, state_d;
    sel_t                  ptr_q, ptr_d;
    logic [NUM_SLOTS-1:0]  valid_d;
    logic                  ready_q;
    logic                  done_d, err_d, wr_en;
    sel_t                  dest;
    word_t                 slot_q [NUM_SLOTS];

    assign wr.in_ready = ready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            slot_valid <= '0;
            ready_q    <= 1'b0;
            frame_done <= 1'b0;
            err_const  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            slot_valid <= valid_d;
            ready_q    <= (state_d == ST_FILL);
            frame_done <= done_d;
            err_const  <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = slot_valid;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        dest    = wr.wr_sel_en ? wr.wr_sel : ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    ptr_d   = '0;
                    valid_d = '0;
                end
            end
            ST_FILL: begin
                // a restart wins over any word offered in the same cycle
                if (start) begin
                    ptr_d   = '0;
                    valid_d = '0;
                end else if (wr.in_valid && ready_q) begin
                    if (dest == SEL_CONST) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en         = 1'b1;
                        valid_d[dest] = 1'b1;
                        if (!wr.wr_sel_en && ptr_q != sel_t'(NUM_SLOTS - 1))
                            ptr_d = ptr_q + sel_t'(1);
                    end
                    if (&valid_d) begin
                        state_d = ST_FULL;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (frame_ack) begin
                    state_d = ST_FILL;
                    ptr_d   = '0;
                    valid_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // slot data survives frame_ack; only a write or reset changes it
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                slot_q[g] <= '0;
            else if (wr_en && dest == sel_t'(g))
                slot_q[g] <= wr.in_data;
        end
    end

    assign data_out_0 = slot_q[0];
    assign data_out_1 = slot_q[1];
    assign data_out_2 = slot_q[2];
    assign data_out_3 = slot_q[3];
    assign data_out_4 = slot_q[4];
    assign data_out_5 = slot_q[5];
    assign data_out_6 = slot_q[6];

endmodule

// File: tb/tb_df_demux.sv
// tb/tb_df_demux.sv - directed bench with a behavioural frame model checked every cycle
module tb_df_demux;
    import df_demux_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic frame_ack = 1'b0;
    word_t data_out_0, data_out_1, data_out_2, data_out_3, data_out_4, data_out_5, data_out_6;
    logic [NUM_SLOTS-1:0] slot_valid;
    logic frame_done, err_const;

    df_demux_if bus ();

    df_demux dut (
        .clk(clk), .reset(reset), .start(start), .wr(bus.slave),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .data_out_3(data_out_3), .data_out_4(data_out_4), .data_out_5(data_out_5),
        .data_out_6(data_out_6), .slot_valid(slot_valid), .frame_done(frame_done),
        .frame_ack(frame_ack), .err_const(err_const)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    word_t dout [NUM_SLOTS];
    always_comb begin
        dout[0] = data_out_0; dout[1] = data_out_1; dout[2] = data_out_2; dout[3] = data_out_3;
        dout[4] = data_out_4; dout[5] = data_out_5; dout[6] = data_out_6;
    end

    // model: phase 0 = waiting for start, 1 = collecting words, 2 = frame held
    int    m_phase = 0;
    int    m_next = 0;
    bit    m_have [NUM_SLOTS] = '{default: 0};
    word_t m_word [NUM_SLOTS] = '{default: '0};
    bit    m_done = 0;
    bit    m_err = 0;

    function automatic bit all_have();
        for (int i = 0; i < NUM_SLOTS; i++) if (!m_have[i]) return 0;
        return 1;
    endfunction

    function automatic logic [NUM_SLOTS-1:0] have_vec();
        logic [NUM_SLOTS-1:0] v;
        for (int i = 0; i < NUM_SLOTS; i++) v[i] = m_have[i];
        return v;
    endfunction

    always @(negedge reset) begin
        m_phase = 0; m_next = 0; m_done = 0; m_err = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin m_have[i] = 0; m_word[i] = '0; end
    end

    always @(posedge clk) begin
        if (reset) begin
            int target;
            m_done = 0;
            m_err = 0;
            if (m_phase == 0 && start) begin
                m_phase = 1; m_next = 0;
                for (int i = 0; i < NUM_SLOTS; i++) m_have[i] = 0;
            end else if (m_phase == 1 && start) begin
                m_next = 0;
                for (int i = 0; i < NUM_SLOTS; i++) m_have[i] = 0;
            end else if (m_phase == 1 && bus.in_valid) begin
                target = bus.wr_sel_en ? int'(bus.wr_sel) : m_next;
                if (target >= NUM_SLOTS) m_err = 1;
                else begin
                    m_word[target] = bus.in_data;
                    m_have[target] = 1;
                    if (!bus.wr_sel_en) m_next = (m_next + 1 > NUM_SLOTS - 1) ? NUM_SLOTS - 1 : m_next + 1;
                end
                if (all_have()) begin m_phase = 2; m_done = 1; end
            end else if (m_phase == 2 && frame_ack) begin
                m_phase = 1; m_next = 0;
                for (int i = 0; i < NUM_SLOTS; i++) m_have[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", 32'(bus.in_ready), 32'(m_phase == 1));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("err_const", 32'(err_const), 32'(m_err));
        check("slot_valid", 32'(slot_valid), 32'(have_vec()));
        for (int i = 0; i < NUM_SLOTS; i++)
            check($sformatf("data_out_%0d", i), 32'(dout[i]), 32'(m_word[i]));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_data = '0; bus.in_valid = 1'b0; bus.wr_sel_en = 1'b0; bus.wr_sel = '0;
        cyc(); cyc();
        check("rst_ready", 32'(bus.in_ready), 32'h0);
        check("rst_valid", 32'(slot_valid), 32'h0);
        check("rst_data0", 32'(data_out_0), 32'h0);
        #2 reset = 1'b1;

        // auto fill of a full frame
        start = 1'b1; cyc(); start = 1'b0;
        check("armed_ready", 32'(bus.in_ready), 32'h1);
        for (int i = 1; i <= 7; i++) begin
            bus.in_valid = 1'b1; bus.in_data = {8'(i), 8'(i)}; cyc();
        end
        check("full_done", 32'(frame_done), 32'h1);
        check("full_ready", 32'(bus.in_ready), 32'h0);
        check("full_valid", 32'(slot_valid), 32'h7F);
        check("full_d0", 32'(data_out_0), 32'h0101);
        check("full_d3", 32'(data_out_3), 32'h0404);
        check("full_d6", 32'(data_out_6), 32'h0707);

        // words offered while the frame is held are ignored
        bus.in_data = 16'hDEAD; cyc();
        check("held_done", 32'(frame_done), 32'h0);
        check("held_d6", 32'(data_out_6), 32'h0707);
        cyc();
        bus.in_valid = 1'b0; frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
        check("ack_ready", 32'(bus.in_ready), 32'h1);
        check("ack_valid", 32'(slot_valid), 32'h0);
        check("ack_d0", 32'(data_out_0), 32'h0101);

        // explicit slot writes
        bus.wr_sel_en = 1'b1; bus.in_valid = 1'b1;
        bus.wr_sel = 3'd6; bus.in_data = 16'hA006; cyc();
        bus.wr_sel = 3'd0; bus.in_data = 16'hA000; cyc();
        bus.wr_sel = 3'd3; bus.in_data = 16'hA003; cyc();
        bus.in_valid = 1'b0;
        check("expl_valid", 32'(slot_valid), 32'h49);
        check("expl_d6", 32'(data_out_6), 32'hA006);
        check("expl_d3", 32'(data_out_3), 32'hA003);
        check("expl_done", 32'(frame_done), 32'h0);

        // constant slot is never writable
        bus.wr_sel = 3'd7; bus.in_data = 16'h1234; bus.in_valid = 1'b1; cyc(); bus.in_valid = 1'b0;
        check("const_err", 32'(err_const), 32'h1);
        check("const_valid", 32'(slot_valid), 32'h49);
        cyc();
        check("const_err_clr", 32'(err_const), 32'h0);

        // auto mode with gaps; pointer still at 0 after explicit writes
        bus.wr_sel_en = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'hB000; cyc();
        bus.in_valid = 1'b0; cyc();
        bus.in_valid = 1'b1; bus.in_data = 16'hB001; cyc();
        bus.in_valid = 1'b0; cyc();
        check("gap_d0", 32'(data_out_0), 32'hB000);
        check("gap_d1", 32'(data_out_1), 32'hB001);
        check("gap_valid", 32'(slot_valid), 32'h4B);
        for (int i = 2; i <= 5; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'hB000 + 16'(i); cyc();
        end
        check("gap_done", 32'(frame_done), 32'h1);
        check("gap_d3", 32'(data_out_3), 32'hB003);
        check("gap_d6", 32'(data_out_6), 32'hA006);
        bus.in_data = 16'hB0FF; cyc();
        check("extra_ready", 32'(bus.in_ready), 32'h0);
        check("extra_d6", 32'(data_out_6), 32'hA006);
        bus.in_valid = 1'b0; frame_ack = 1'b1; cyc(); frame_ack = 1'b0;

        // restart in FILL discards the coincident word
        bus.in_valid = 1'b1; bus.in_data = 16'hC000; cyc();
        start = 1'b1; bus.in_data = 16'hC111; cyc(); start = 1'b0;
        check("rs_valid", 32'(slot_valid), 32'h0);
        check("rs_d1", 32'(data_out_1), 32'hB001);
        bus.in_data = 16'hC222; cyc();
        check("rs_d0", 32'(data_out_0), 32'hC222);
        frame_ack = 1'b1; bus.in_data = 16'hC333; cyc(); frame_ack = 1'b0;
        check("stray_ack_valid", 32'(slot_valid), 32'h3);
        bus.in_data = 16'hC444; cyc();
        bus.in_valid = 1'b0;

        // asynchronous reset mid-frame
        @(posedge clk); #3 reset = 1'b0; #1;
        check("arst_d0", 32'(data_out_0), 32'h0);
        check("arst_valid", 32'(slot_valid), 32'h0);
        check("arst_ready", 32'(bus.in_ready), 32'h0);
        cyc(); #2 reset = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 16'hEEEE; cyc();
        check("post_rst_ready", 32'(bus.in_ready), 32'h0);
        check("post_rst_d0", 32'(data_out_0), 32'h0);
        start = 1'b1; cyc(); start = 1'b0; bus.in_valid = 1'b0;
        check("post_start_ready", 32'(bus.in_ready), 32'h1);
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/df_demux.md
Name: df_demux

Overview:
- Write-back distributor for the neuron dataflow path; the inverse of the 8-to-1 operand selector.
- Accepts a stream of result words over a valid/ready handshake and scatters them into NUM_SLOTS holding registers.
- Uses either an auto-incrementing slot pointer or an explicit slot select.
- Signals frame completion once every slot is filled and holds the frame until downstream acknowledges it.

Parameters:
- DATA_WIDTH, 16, word width; matches the codebase data word bus (Q3.12 fixed point, 1.0 = 16'h1000).
- NUM_SLOTS, 7, writable slots 0..NUM_SLOTS-1; select value 7 is the constant-1 slot and is never writable.
- SEL_WIDTH, 3, width of the slot select and pointer.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; arms the block for a new frame (IDLE->FILL).
- in_data  input  DATA_WIDTH  result word to store.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- wr_sel_en  input  1  1 = use wr_sel as the destination; 0 = use the internal pointer.
- wr_sel  input  SEL_WIDTH  explicit destination slot.
- data_out_0 .. data_out_6  output  DATA_WIDTH each  slot registers.
- slot_valid  output  NUM_SLOTS  per-slot written flag.
- frame_done  output  1  one-cycle pulse when the frame becomes complete.
- frame_ack  input  1  downstream consumed the frame; release it.
- err_const  output  1  one-cycle pulse when a write targets slot 7.

Behaviour:
- Reset (asynchronous, reset=0) forces:
  - state=IDLE, pointer=0
  - all data_out_n=0, slot_valid=0
  - in_ready=0, frame_done=0, err_const=0
- States are IDLE, FILL and FULL; all outputs are registered.
- IDLE:
  - in_ready=0.
  - start=1 -> FILL next cycle; pointer=0; slot_valid cleared.
- FILL:
  - in_ready=1.
  - A transfer occurs when in_valid && in_ready.
  - Destination is wr_sel if wr_sel_en=1, else the pointer.
  - Destination < NUM_SLOTS: data_out[dest] <= in_data and slot_valid[dest] <= 1 on the same edge.
  - Rewriting an already-valid slot overwrites its data; slot_valid is unchanged.
  - Destination 7: no write; err_const=1 for the following cycle; the pointer does not move.
  - The pointer increments only on an auto-mode transfer. It saturates at NUM_SLOTS-1 and never wraps into slot 7.
  - Explicit-mode transfers leave the pointer unchanged.
- FILL -> FULL:
  - Triggered on the edge where slot_valid becomes all ones for slots 0..NUM_SLOTS-1.
  - frame_done is high for exactly the first FULL cycle.
- FULL:
  - in_ready=0; data_out and slot_valid hold.
  - in_valid is ignored; no transfer occurs.
  - frame_ack=1 -> FILL next cycle; slot_valid cleared; pointer=0; data_out retains old values until overwritten.
  - start is ignored.
- start received in FILL: restarts the frame (pointer=0, slot_valid cleared). A transfer in that same cycle is discarded.
- frame_ack received outside FULL: ignored.
- Latency: a word accepted on edge N is visible on data_out at N (registered output, available in cycle N+1).
  - frame_done asserts the cycle after the completing transfer.
- Throughput: one word per cycle in FILL, with no bubbles.
- Reset asserted mid-frame: immediate clear of all state; the partial frame is lost.

Decomposition:
- Shared package/header (stddef): DATA_WIDTH, the word data and word address bus ranges, CONST_ONE=16'h1000, SEL_CONST=3'h7, and the state encodings for IDLE/FILL/FULL.
- No sub-module; the slot register bank is a generate loop inside df_demux.

Test Plan:
- Reset, start, then auto mode: 7 back-to-back words 16'h0101..16'h0707 with in_valid=1.
  - data_out_n = 16'h0n0n.
  - slot_valid = 7'h7F.
  - frame_done is a single-cycle pulse one cycle after the 7th transfer.
  - in_ready drops to 0.
- While in FULL, drive in_valid=1 with in_data=16'hDEAD.
  - No output changes.
  - Then frame_ack=1 -> in_ready=1 and slot_valid=0 next cycle; data_out_0 still reads 16'h0101.
- Explicit mode: wr_sel = 6,0,3, data 16'hA006, 16'hA000, 16'hA003.
  - The three slots are written; slot_valid = 7'h49.
  - Pointer remains 0; no frame_done.
- Write with wr_sel_en=1, wr_sel=7, data 16'h1234.
  - err_const pulses one cycle; no slot changes; slot_valid unchanged.
- Auto mode with in_valid toggling 1,0,1,0.
  - Only valid cycles advance the pointer.
  - An 8th auto word after 7 (with slot 6 rewritten, frame not yet acked) cannot occur: confirm in_ready=0.
- Assert reset=0 asynchronously mid-FILL after 3 words.
  - All outputs are 0 immediately, with no clock edge needed.
  - After release, start is required before in_ready rises.
